// File: rtl/cv32e41p_trace_pkg.sv
// Shared types and default widths for the illegal-instruction trace path.
package cv32e41p_trace_pkg;

    localparam int unsigned TRACE_TS_WIDTH   = 32;
    localparam int unsigned TRACE_DROP_WIDTH = 16;

    typedef struct packed {
        logic [31:0]               pc;
        logic [31:0]               instr;
        logic [3:0]                hart;
        logic [TRACE_TS_WIDTH-1:0] ts;
    } illegal_evt_t;

endpackage

// File: rtl/cv32e41p_trace_fifo.sv
// Generic synchronous FIFO; pointers carry one extra MSB to tell full from empty.
module cv32e41p_trace_fifo
    import cv32e41p_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = illegal_evt_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     wdata,
    output logic full,
    input  logic pop,
    output logic empty,
    output T     rdata
);

    localparam int unsigned AW = $clog2(DEPTH);

    T            mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees the slot in the same edge, so a push into a full FIFO is still taken.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/cv32e41p_illegal_insn_tracer.sv
// Captures decoder-flagged illegal instructions with a cycle timestamp into a small
// FIFO drained over a valid/ready port; overflowed events are counted.
module cv32e41p_illegal_insn_tracer
    import cv32e41p_trace_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned TS_WIDTH   = TRACE_TS_WIDTH,
    parameter int unsigned DROP_WIDTH = TRACE_DROP_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  is_decoding_i,
    input  logic                  illegal_insn_dec_i,
    input  logic [31:0]           hart_id_i,
    input  logic [31:0]           pc_id_i,
    input  logic [31:0]           instr_id_i,
    input  logic                  clear_i,
    output logic                  evt_valid_o,
    input  logic                  evt_ready_i,
    output logic [31:0]           evt_pc_o,
    output logic [31:0]           evt_instr_o,
    output logic [3:0]            evt_hart_o,
    output logic [TS_WIDTH-1:0]   evt_time_o,
    output logic [DROP_WIDTH-1:0] drop_cnt_o,
    output logic                  overflow_o
);

    typedef struct packed {
        logic [31:0]         pc;
        logic [31:0]         instr;
        logic [3:0]          hart;
        logic [TS_WIDTH-1:0] ts;
    } evt_t;

    logic [TS_WIDTH-1:0]   ts_q;
    logic                  prev_raw_q;
    logic [31:0]           prev_pc_q;
    logic [DROP_WIDTH-1:0] drop_cnt_q;
    logic                  overflow_q;

    logic raw;
    logic new_evt;
    logic fifo_full;
    logic fifo_empty;
    logic drop;
    evt_t wdata;
    evt_t rdata;
    evt_t head;
    logic unused_hart;

    assign unused_hart = ^hart_id_i[31:4];

    assign raw     = is_decoding_i & illegal_insn_dec_i;
    // An ID stall repeats the same PC; only its first flagged cycle is an event.
    assign new_evt = raw & ~(prev_raw_q & (prev_pc_q == pc_id_i));

    assign wdata.pc    = pc_id_i;
    assign wdata.instr = instr_id_i;
    assign wdata.hart  = hart_id_i[3:0];
    assign wdata.ts    = ts_q;

    assign drop = new_evt & fifo_full & ~(evt_ready_i & ~fifo_empty);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts_q       <= '0;
            prev_raw_q <= 1'b0;
            prev_pc_q  <= '0;
        end else begin
            ts_q       <= ts_q + 1'b1;
            prev_raw_q <= raw;
            prev_pc_q  <= pc_id_i;
        end
    end

    // A drop coinciding with clear restarts the count at one rather than zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (clear_i)
                drop_cnt_q <= {{(DROP_WIDTH-1){1'b0}}, 1'b1};
            else if (drop_cnt_q != '1)
                drop_cnt_q <= drop_cnt_q + 1'b1;
        end else if (clear_i) begin
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end
    end

    cv32e41p_trace_fifo #(
        .DEPTH (DEPTH),
        .T     (evt_t)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (new_evt),
        .wdata (wdata),
        .full  (fifo_full),
        .pop   (evt_ready_i),
        .empty (fifo_empty),
        .rdata (rdata)
    );

    // Storage is not cleared on reset, so the head is masked while empty.
    assign head = fifo_empty ? '0 : rdata;

    assign evt_valid_o = ~fifo_empty;
    assign evt_pc_o    = head.pc;
    assign evt_instr_o = head.instr;
    assign evt_hart_o  = head.hart;
    assign evt_time_o  = head.ts;
    assign drop_cnt_o  = drop_cnt_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_cv32e41p_illegal_insn_tracer.sv
// Directed bench for the illegal-instruction tracer (DEPTH=4, 8-bit timestamp, 2-bit drop counter).
module tb_cv32e41p_illegal_insn_tracer;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_decoding;
    logic        illegal_insn_dec;
    logic [31:0] hart_id;
    logic [31:0] pc_id;
    logic [31:0] instr_id;
    logic        clear;
    logic        evt_valid;
    logic        evt_ready;
    logic [31:0] evt_pc;
    logic [31:0] evt_instr;
    logic [3:0]  evt_hart;
    logic [7:0]  evt_time;
    logic [1:0]  drop_cnt;
    logic        overflow;

    int unsigned passes = 0;
    int unsigned checks = 0;
    int unsigned now    = 0;

    cv32e41p_illegal_insn_tracer #(
        .DEPTH      (4),
        .TS_WIDTH   (8),
        .DROP_WIDTH (2)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .is_decoding_i      (is_decoding),
        .illegal_insn_dec_i (illegal_insn_dec),
        .hart_id_i          (hart_id),
        .pc_id_i            (pc_id),
        .instr_id_i         (instr_id),
        .clear_i            (clear),
        .evt_valid_o        (evt_valid),
        .evt_ready_i        (evt_ready),
        .evt_pc_o           (evt_pc),
        .evt_instr_o        (evt_instr),
        .evt_hart_o         (evt_hart),
        .evt_time_o         (evt_time),
        .drop_cnt_o         (drop_cnt),
        .overflow_o         (overflow)
    );

    always #5 clk = ~clk;

    // now mirrors the timestamp the DUT holds during the current cycle
    task automatic tick();
        @(posedge clk);
        if (rst) now = 0;
        else     now = (now + 1) % 256;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic ev(input logic [31:0] pc);
        is_decoding      = 1'b1;
        illegal_insn_dec = 1'b1;
        pc_id            = pc;
        instr_id         = pc ^ 32'hDEAD_0000;
    endtask

    task automatic idle();
        is_decoding = 1'b0;
    endtask

    initial begin
        rst = 1'b1; is_decoding = 1'b0; illegal_insn_dec = 1'b0;
        hart_id = 32'hABCD_0123; pc_id = '0; instr_id = '0;
        clear = 1'b0; evt_ready = 1'b0;
        tick(); tick();
        check("rst_valid", {31'd0, evt_valid}, 32'd0);
        check("rst_pc", evt_pc, 32'd0);
        check("rst_time", {24'd0, evt_time}, 32'd0);
        check("rst_drop", {30'd0, drop_cnt}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b0;

        // single event recorded at counter 5
        repeat (5) tick();
        ev(32'h80); instr_id = 32'hFFFF_FFFF;
        tick();
        is_decoding = 1'b0;                  // illegal flag alone is not an event
        check("first_valid", {31'd0, evt_valid}, 32'd1);
        check("first_pc", evt_pc, 32'h80);
        check("first_instr", evt_instr, 32'hFFFF_FFFF);
        check("first_hart", {28'd0, evt_hart}, 32'h3);
        check("first_time", {24'd0, evt_time}, 32'd5);
        tick();
        check("hold_valid", {31'd0, evt_valid}, 32'd1);
        check("hold_pc", evt_pc, 32'h80);
        check("hold_time", {24'd0, evt_time}, 32'd5);
        evt_ready = 1'b1;
        tick();
        check("pop_empty", {31'd0, evt_valid}, 32'd0);
        evt_ready = 1'b0;

        // stall on one PC, gap, then the same PC again (now=8)
        ev(32'h100);
        repeat (4) tick();
        idle();
        tick();
        ev(32'h100);
        tick();
        idle();
        check("stall_pc", evt_pc, 32'h100);
        check("stall_time1", {24'd0, evt_time}, 32'd8);
        evt_ready = 1'b1;
        tick();
        check("stall_valid2", {31'd0, evt_valid}, 32'd1);
        check("stall_time2", {24'd0, evt_time}, 32'd13);
        tick();
        check("stall_single", {31'd0, evt_valid}, 32'd0);
        evt_ready = 1'b0;

        // six distinct events into a depth-4 FIFO (now=16)
        for (int i = 0; i < 6; i++) begin
            ev(32'h200 + 32'(4 * i));
            tick();
        end
        idle();
        check("ovf_drop", {30'd0, drop_cnt}, 32'd2);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", {31'd0, evt_valid}, 32'd1);
            check("drain_pc", evt_pc, 32'h200 + 32'(4 * i));
            check("drain_time", {24'd0, evt_time}, 32'(16 + i));
            tick();
        end
        check("drain_empty", {31'd0, evt_valid}, 32'd0);
        evt_ready = 1'b0;

        // full FIFO: pop and push in the same cycle
        for (int i = 0; i < 4; i++) begin
            ev(32'h300 + 32'(4 * i));
            tick();
        end
        check("fill_nodrop", {30'd0, drop_cnt}, 32'd2);
        ev(32'h400);
        evt_ready = 1'b1;
        tick();
        idle();
        check("fullpop_drop", {30'd0, drop_cnt}, 32'd2);
        check("fullpop_head", evt_pc, 32'h304);
        tick(); tick();
        check("fullpop_pc3", evt_pc, 32'h30C);
        tick();
        check("fullpop_last", evt_pc, 32'h400);
        check("fullpop_instr", evt_instr, 32'hDEAD_0400);
        tick();
        check("fullpop_empty", {31'd0, evt_valid}, 32'd0);

        // empty with push and ready together: entry is kept
        ev(32'h500);
        tick();
        idle();
        check("empty_push_valid", {31'd0, evt_valid}, 32'd1);
        check("empty_push_pc", evt_pc, 32'h500);
        tick();
        check("empty_push_pop", {31'd0, evt_valid}, 32'd0);
        evt_ready = 1'b0;

        // saturate the 2-bit drop counter, then clear racing a drop
        for (int i = 0; i < 6; i++) begin
            ev(32'h600 + 32'(4 * i));
            tick();
        end
        check("sat_drop", {30'd0, drop_cnt}, 32'd3);
        ev(32'h618);
        clear = 1'b1;
        tick();
        idle();
        check("clear_drop_cnt", {30'd0, drop_cnt}, 32'd1);
        check("clear_drop_ovf", {31'd0, overflow}, 32'd1);
        tick();
        clear = 1'b0;
        check("clear_cnt", {30'd0, drop_cnt}, 32'd0);
        check("clear_ovf", {31'd0, overflow}, 32'd0);
        check("clear_fifo_head", evt_pc, 32'h600);
        evt_ready = 1'b1;
        repeat (4) tick();
        check("clear_drain", {31'd0, evt_valid}, 32'd0);
        evt_ready = 1'b0;

        // timestamp wrap: events at 0xFF, 0x01, 0x02
        for (int g = 0; g < 300 && now != 255; g++) tick();
        ev(32'h700);
        tick();
        idle();
        tick();
        ev(32'h704);
        tick();
        ev(32'h708);
        tick();
        idle();
        check("wrap_pc", evt_pc, 32'h700);
        check("wrap_time_ff", {24'd0, evt_time}, 32'hFF);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("wrap_time_01", {24'd0, evt_time}, 32'h01);

        // reset with entries buffered and a drop pending in the counters
        for (int i = 0; i < 3; i++) begin
            ev(32'h70C + 32'(4 * i));
            tick();
        end
        idle();
        check("pre_rst_drop", {30'd0, drop_cnt}, 32'd1);
        check("pre_rst_valid", {31'd0, evt_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", {31'd0, evt_valid}, 32'd0);
        check("mid_rst_pc", evt_pc, 32'd0);
        check("mid_rst_drop", {30'd0, drop_cnt}, 32'd0);
        check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        tick();
        check("post_rst_valid", {31'd0, evt_valid}, 32'd0);
        check("post_rst_time", {24'd0, evt_time}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
